data_mem_responder: RTL

Data-memory responder: the memory-side end of the pipeline's MEM-stage load/store interface. Accepts one request at a time over a valid/ready handshake and performs word, halfword or byte accesses on a little-endian word array. Returns load data sign- or zero-extended per `load_mode` after a programmable number of wait states. Replaces the zero-latency data RAM so stall logic can be exercised against realistic memory latency.

---
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/data_mem_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   MEM-stage load/store bus between the pipeline (master) and the data
//   memory responder (slave).
//   Request : req_valid/req_ready handshake carrying mem_read, mem_write,
//             load_mode, address, write_data.
//   Response: resp_valid one-cycle pulse with read_data and misaligned.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  load_mode;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        resp_valid;
  logic [31:0] read_data;
  logic        misaligned;

  modport master (
    output req_valid, mem_read, mem_write, load_mode, address, write_data,
    input  req_ready, resp_valid, read_data, misaligned
  );

  modport slave (
    input  req_valid, mem_read, mem_write, load_mode, address, write_data,
    output req_ready, resp_valid, read_data, misaligned
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side end of the MEM-stage load/store interface. One request at a
//   time; word/halfword/byte access on a little-endian word array with
//   WAIT_STATES cycles of latency before a one-cycle response pulse.
//   Parameters: DEPTH_WORDS (power of two), WAIT_STATES (0 allowed).
//   Ports: clk, rst (sync, active-high), bus (data_mem_responder_if.slave).
//   Optional feature: define DMEM_MISALIGN_CHECK_EN to flag misaligned
//   word/halfword requests (no store, zero load data). Without it the
//   offending low address bits are forced to zero and misaligned stays 0.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  data_mem_responder_if.slave    bus
);
  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam int CW        = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // request captured at the handshake
  logic        lat_rd, lat_wr;
  logic [1:0]  lat_mode;
  logic [31:0] lat_addr, lat_wdata;

  logic [NUM_LANES-1:0][7:0] mem [DEPTH_WORDS];

  logic fire, commit;
  assign fire   = (state == IDLE) && bus.req_valid && bus.req_ready;
  // commit = the edge that enters RESP; with zero wait states that is the
  // acceptance edge itself, so the live bus fields are used then
  assign commit = (WAIT_STATES == 0) ? fire : ((state == WAIT) && (cnt == '0));

  logic        op_rd, op_wr;
  logic [1:0]  op_mode;
  logic [31:0] op_addr, op_wdata;
  assign op_rd    = (state == IDLE) ? bus.mem_read   : lat_rd;
  assign op_wr    = (state == IDLE) ? bus.mem_write  : lat_wr;
  assign op_mode  = (state == IDLE) ? bus.load_mode  : lat_mode;
  assign op_addr  = (state == IDLE) ? bus.address    : lat_addr;
  assign op_wdata = (state == IDLE) ? bus.write_data : lat_wdata;

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, op_addr[31:AW+2], 1'b0};

  // effective byte lane and alignment error
  logic [1:0] lane;
  logic       mis;
  always_comb begin
    lane = op_addr[1:0];
    mis  = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (op_mode == 2'b00)      mis = |op_addr[1:0];
    else if (op_mode == 2'b01) mis = op_addr[0];
    mis = mis & (op_rd | op_wr);
`else
    if (op_mode == 2'b00)      lane = 2'b00;
    else if (op_mode == 2'b01) lane = {op_addr[1], 1'b0};
`endif
  end

  logic [AW-1:0]             widx;
  logic [NUM_LANES-1:0][7:0] rword;
  logic [NUM_LANES-1:0]      be;
  logic [NUM_LANES-1:0][7:0] wd;
  assign widx  = op_addr[2 +: AW];
  assign rword = mem[widx];

  // per-lane byte enable and replicated store data
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [1:0] LN = 2'(g);
    assign be[g] = (op_mode == 2'b00)
                 | ((op_mode == 2'b01) & (LN[1] == lane[1]))
                 | (op_mode[1] & (LN == lane));
    assign wd[g] = (op_mode == 2'b00) ? op_wdata[8*g +: 8]
                 : (op_mode == 2'b01) ? op_wdata[8*(g%2) +: 8]
                 :                      op_wdata[7:0];
  end

  logic do_write;
  assign do_write = commit & op_wr & ~mis;

  always_ff @(posedge clk) begin
    if (do_write && !rst) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (be[i]) mem[widx][i] <= wd[i];
    end
  end

  // load extraction and extension
  logic [15:0] hw;
  logic [7:0]  by;
  logic [31:0] load_val, ld_data;
  always_comb begin
    hw = lane[1] ? rword[3:2] : rword[1:0];
    by = rword[lane];
    unique case (op_mode)
      2'b00:   load_val = rword;
      2'b01:   load_val = {{16{hw[15]}}, hw};
      2'b10:   load_val = {{24{by[7]}}, by};
      default: load_val = {24'd0, by};
    endcase
    // a store (even with mem_read set) or a no-op returns zero
    ld_data = (op_rd & ~op_wr & ~mis) ? load_val : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.read_data  <= 32'd0;
      bus.misaligned <= 1'b0;
      lat_rd         <= 1'b0;
      lat_wr         <= 1'b0;
      lat_mode       <= 2'b00;
      lat_addr       <= 32'd0;
      lat_wdata      <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.req_ready  <= 1'b1;
          bus.resp_valid <= 1'b0;
          if (fire) begin
            lat_rd        <= bus.mem_read;
            lat_wr        <= bus.mem_write;
            lat_mode      <= bus.load_mode;
            lat_addr      <= bus.address;
            lat_wdata     <= bus.write_data;
            bus.req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.read_data  <= ld_data;
              bus.misaligned <= mis;
            end else begin
              state <= WAIT;
              cnt   <= CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.read_data  <= ld_data;
            bus.misaligned <= mis;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.misaligned <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
        default: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b0;
        end
      endcase
    end
  end
endmodule
